// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, 16x oversampled, majority vote per bit.
// Presents each byte on an rx_rdy / rx_ack handshake.
module uart_rx_core #(
  parameter int CLOCK      = 100_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_enable,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = CLOCK / (BAUDRATE * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        r_state;
  logic [1:0]    r_sync;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_s;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_v7;
  logic          r_v8;
  logic          r_bit;
  logic [7:0]    r_data;
  logic          r_rdy;
  logic          r_ferr;
  logic          r_ovr;

  logic w_rx_s;
  logic w_tick;
  logic w_maj;

  assign w_rx_s = r_sync[1];
  assign w_tick = (r_tcnt == TMAX);
  // Vote of s=7,8 samples with the live s=9 sample
  assign w_maj  = (r_v7 & r_v8) | (r_v7 & w_rx_s) | (r_v8 & w_rx_s);

  assign rx_data   = r_data;
  assign rx_rdy    = r_rdy;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sync  <= 2'b11;
      r_tcnt  <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_v7    <= 1'b1;
      r_v8    <= 1'b1;
      r_bit   <= 1'b1;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_tcnt <= w_tick ? '0 : r_tcnt + TW'(1);
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;

      if (rx_ack && r_rdy) r_rdy <= 1'b0;

      if (!rx_enable) begin
        r_state <= IDLE;
      end else if (w_tick) begin
        if (r_state != IDLE) begin
          r_s <= r_s + 4'd1;
          if (r_s == 4'd7) r_v7 <= w_rx_s;
          if (r_s == 4'd8) r_v8 <= w_rx_s;
          if (r_s == 4'd9) r_bit <= w_maj;
        end
        unique case (r_state)
          IDLE: begin
            if (!w_rx_s) begin
              r_state <= START;
              r_s     <= '0;
            end
          end
          START: begin
            r_idx <= '0;
            if (r_s == 4'd15) r_state <= r_bit ? IDLE : DATA;
          end
          DATA: begin
            if (r_s == 4'd15) begin
              r_shift[r_idx] <= r_bit;
              r_idx          <= r_idx + 3'd1;
              if (r_idx == 3'd7) r_state <= STOP;
            end
          end
          STOP: begin
            // Decide early at s=9 so a back-to-back start is not missed
            if (r_s == 4'd9) begin
              r_state <= IDLE;
              if (w_maj) begin
                r_data <= r_shift;
                r_rdy  <= 1'b1;
                r_ovr  <= r_rdy && !rx_ack;
              end else begin
                r_ferr <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed scenarios plus random frames
// checked against a byte-level receive model.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rx_enable = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cnt_fe = 0;
  int cnt_ov = 0;
  int rise_cyc = -1;
  logic prev_rdy = 1'b0;
  int t_start = 0;

  uart_rx_core #(
    .CLOCK(1_600_000),
    .BAUDRATE(10_000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_enable(rx_enable),
    .rx_data(rx_data),
    .rx_rdy(rx_rdy),
    .rx_ack(rx_ack),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err === 1'b1) cnt_fe++;
    if (overrun === 1'b1) cnt_ov++;
    if (rx_rdy === 1'b1 && prev_rdy !== 1'b1) rise_cyc = cyc;
    prev_rdy = rx_rdy;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; returns at a negedge 1600 clk later
  task automatic send_frame(input logic [7:0] b, input bit stop,
                            input int cut);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    t_start = cyc;
    for (int i = 0; i < 1600; i++) begin
      rx = (i < cut) ? f[i / 160] : 1'b1;
      @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  int fe0, ov0, lat, tgt, gap;
  logic [7:0] b, exp_data;
  logic exp_rdy;
  bit stop, exp_ov;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", int'(rx_data), 0);
    chk("rst_rdy", int'(rx_rdy), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_ovr", int'(overrun), 0);
    rst = 1'b1;
    repeat (50) @(negedge clk);

    fe0 = cnt_fe;
    send_frame(8'h55, 1'b1, 1600);
    lat = rise_cyc - t_start;
    chk("b55_data", int'(rx_data), 8'h55);
    chk("b55_rdy", int'(rx_rdy), 1);
    chk("b55_ferr", cnt_fe - fe0, 0);
    chk("b55_latency_ok", int'(lat >= 1520 && lat <= 1560), 1);
    repeat (500) @(negedge clk);
    chk("b55_hold", int'(rx_rdy), 1);

    pulse_ack();
    chk("ack_rdy", int'(rx_rdy), 0);
    chk("ack_data", int'(rx_data), 8'h55);
    pulse_ack();
    chk("ack2_rdy", int'(rx_rdy), 0);

    fe0 = cnt_fe;
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_rdy", int'(rx_rdy), 0);
    chk("glitch_ferr", cnt_fe - fe0, 0);
    send_frame(8'h3C, 1'b1, 1600);
    chk("b3c_data", int'(rx_data), 8'h3C);
    chk("b3c_rdy", int'(rx_rdy), 1);
    pulse_ack();

    repeat (100) @(negedge clk);
    fe0 = cnt_fe;
    ov0 = cnt_ov;
    send_frame(8'hA3, 1'b0, 1600);
    chk("fe_pulses", cnt_fe - fe0, 1);
    chk("fe_rdy", int'(rx_rdy), 0);
    chk("fe_data", int'(rx_data), 8'h3C);
    chk("fe_ovr", cnt_ov - ov0, 0);
    repeat (300) @(negedge clk);
    send_frame(8'h01, 1'b1, 1600);
    chk("b01_data", int'(rx_data), 8'h01);
    chk("b01_rdy", int'(rx_rdy), 1);
    pulse_ack();

    repeat (100) @(negedge clk);
    ov0 = cnt_ov;
    send_frame(8'h12, 1'b1, 1600);
    send_frame(8'h34, 1'b1, 1600);
    chk("ovr_pulses", cnt_ov - ov0, 1);
    chk("ovr_data", int'(rx_data), 8'h34);
    chk("ovr_rdy", int'(rx_rdy), 1);
    pulse_ack();

    repeat (100) @(negedge clk);
    ov0 = cnt_ov;
    send_frame(8'h56, 1'b1, 1600);
    lat = rise_cyc - t_start;
    tgt = t_start + 1600 + lat;
    fork
      send_frame(8'h78, 1'b1, 1600);
      begin
        while (cyc < tgt - 1) @(negedge clk);
        pulse_ack();
      end
    join
    chk("coack_ovr", cnt_ov - ov0, 0);
    chk("coack_rdy", int'(rx_rdy), 1);
    chk("coack_data", int'(rx_data), 8'h78);

    repeat (100) @(negedge clk);
    fe0 = cnt_fe;
    fork
      send_frame(8'h00, 1'b1, 505);
      begin
        repeat (500) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    join
    chk("mrst_data", int'(rx_data), 0);
    chk("mrst_rdy", int'(rx_rdy), 0);
    chk("mrst_ferr", cnt_fe - fe0, 0);
    repeat (100) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1600);
    chk("mrst_c3_data", int'(rx_data), 8'hC3);
    chk("mrst_c3_rdy", int'(rx_rdy), 1);

    fe0 = cnt_fe;
    fork
      send_frame(8'h5A, 1'b1, 1600);
      begin
        repeat (400) @(negedge clk);
        rx_enable = 1'b0;
      end
    join
    chk("dis_data", int'(rx_data), 8'hC3);
    chk("dis_ferr", cnt_fe - fe0, 0);
    pulse_ack();
    chk("dis_ack_rdy", int'(rx_rdy), 0);
    rx_enable = 1'b1;
    repeat (100) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1600);
    chk("dis_c3_data", int'(rx_data), 8'hC3);
    chk("dis_c3_rdy", int'(rx_rdy), 1);

    exp_data = 8'hC3;
    exp_rdy = 1'b1;
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      if ($urandom_range(1) == 1) begin
        pulse_ack();
        exp_rdy = 1'b0;
      end
      fe0 = cnt_fe;
      ov0 = cnt_ov;
      send_frame(b, stop, 1600);
      exp_ov = stop && exp_rdy;
      if (stop) begin
        exp_data = b;
        exp_rdy = 1'b1;
      end
      chk("rnd_data", int'(rx_data), int'(exp_data));
      chk("rnd_rdy", int'(rx_rdy), int'(exp_rdy));
      chk("rnd_ferr", cnt_fe - fe0, int'(!stop));
      chk("rnd_ovr", cnt_ov - ov0, int'(exp_ov));
      gap = stop ? int'($urandom_range(100)) : 200 + int'($urandom_range(100));
      repeat (gap) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- 8N1 UART receiver with 16x oversampling: samples the serial rx line, validates start and stop bits, and presents each received byte on a ready/acknowledge handshake.
- Sits between the board rx pin and the byte consumer (echo/LED logic); produces the rx_data / rx_rdy / rx_ack interface used at top level.
- Single clock domain. Baud tick is generated internally, so no separate rx clock is needed.

Parameters:
- CLOCK, 100e6, system clock frequency in Hz.
- BAUDRATE, 9600, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; fixed at 16. Other values are unsupported.
- DIV (localparam), CLOCK/(BAUDRATE*OVERSAMPLE) truncated; 651 at defaults. Tick counter width is clog2(DIV).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low.
- rx  input  1  asynchronous serial line, idle high.
- rx_enable  input  1  receiver enable; low holds the FSM in IDLE.
- rx_data  output  8  last received byte, LSB first on the line.
- rx_rdy  output  1  byte valid; held until acknowledged.
- rx_ack  input  1  consumer acknowledge; sampled on clk.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a byte completes while rx_rdy is already high.

Behaviour:
- Reset (rst==0 at a clk edge):
  - rx_data=0, rx_rdy=0, frame_err=0, overrun=0.
  - FSM=IDLE, tick/bit counters=0, synchronizer flops=1.
  - Reset mid-frame aborts the frame; the partial byte is discarded.
- Synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s, adding 2 clk of latency.
- Tick generator: counter 0..DIV-1; tick=1 for one clk when counter==DIV-1. Free-running, including while in IDLE.
- Bit timing: sub-tick counter s counts 0..15 per bit. Each bit value is the majority of rx_s at s=7,8,9.
- IDLE:
  - On a tick with rx_s==0 and rx_enable==1, go to START with s=0.
- START:
  - At s=15: majority 0 -> DATA with bit index 0. Majority 1 -> IDLE (glitch rejected, no outputs change).
- DATA:
  - At s=15, shift the majority into the shift register at bit[index].
  - index 0..7; after index 7 go to STOP.
- STOP: the decision is made at s=9, early, to allow resync to a back-to-back start bit.
  - Majority 1: rx_data<=shift, rx_rdy<=1 on the next clk edge. If rx_rdy was already 1 and rx_ack is not high this cycle, overrun=1 for that one cycle.
  - Majority 0: frame_err=1 for one cycle. rx_data and rx_rdy are unchanged.
  - Either way, return to IDLE.
- Handshake:
  - rx_ack==1 while rx_rdy==1 clears rx_rdy on the next edge. rx_data is retained.
  - rx_ack while rx_rdy==0 is ignored.
  - Byte completion and rx_ack in the same cycle: the new byte wins. rx_rdy stays 1, rx_data is updated, no overrun.
- rx_enable:
  - Deasserting it mid-frame returns the FSM to IDLE next edge and discards the frame.
  - rx_rdy/rx_data are unaffected; the handshake still works while disabled.
- Latency: rx_rdy rises ≈ 9.5 bit times + 2 clk + ≤1 tick after the start-bit falling edge.
- Frame error: no byte is delivered, and overrun is never pulsed for a framing-error frame.

Test Plan: all scenarios use CLOCK=1_600_000, BAUDRATE=10000, so DIV=10 and 1 bit = 160 clk.
- Send frame 0x55 with valid stop -> rx_data=0x55, rx_rdy=1 about 1520 clk after the start edge, frame_err=0. rx_rdy stays high 500 clk with no ack.
- Then pulse rx_ack for 1 clk -> rx_rdy=0 on the next edge, rx_data stays 0x55. A second rx_ack is ignored.
- Low glitch of 40 clk on idle rx -> FSM returns to IDLE, rx_rdy stays 0, no frame_err. A following frame 0x3C is received correctly.
- Frame 0xA3 with stop bit driven low -> frame_err pulses exactly 1 clk, rx_rdy stays 0, rx_data unchanged. A next frame 0x01 is received OK.
- Back-to-back 0x12, 0x34 without ack -> overrun pulses 1 clk at the second completion, rx_data=0x34, rx_rdy=1. Repeat with rx_ack coincident with the second completion -> no overrun, rx_rdy=1.
- Abort cases, each followed by frame 0xC3 received correctly:
  - rst low for 1 clk mid-DATA -> all outputs 0.
  - rx_enable low mid-frame -> no byte delivered.
